// File: rtl/div_result_bcd.sv
// rtl/div_result_bcd.sv - divider result to BCD converter (6-step double-dabble)
// Captures quotient/remainder, converts both to two BCD digits, presents them with err.
module div_result_bcd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] quo,
  input  logic [5:0] rem,
  input  logic [2:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] quo_tens,
  output logic [3:0] quo_ones,
  output logic [3:0] rem_tens,
  output logic [3:0] rem_ones,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state, state_n;
  logic [2:0]  cnt;
  logic [5:0]  bin_q, bin_r;
  logic [7:0]  bcd_q, bcd_r;
  logic        dz;
  logic [13:0] step_q, step_r;

  // One double-dabble step: add 3 to any nibble >= 5, then shift {bcd, bin} left.
  function automatic logic [13:0] dd_step(input logic [7:0] bcd, input logic [5:0] bin);
    logic [7:0] adj;
    adj = bcd;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    return {adj, bin} << 1;
  endfunction

  assign step_q    = dd_step(bcd_q, bin_q);
  assign step_r    = dd_step(bcd_r, bin_r);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = CONV;
      CONV:    if (cnt == 3'd5) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      bin_q    <= 6'd0;
      bin_r    <= 6'd0;
      bcd_q    <= 8'd0;
      bcd_r    <= 8'd0;
      dz       <= 1'b0;
      quo_tens <= 4'h0;
      quo_ones <= 4'h0;
      rem_tens <= 4'h0;
      rem_ones <= 4'h0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_q <= quo;
            bin_r <= rem;
            dz    <= (divisor == 3'd0);
            bcd_q <= 8'd0;
            bcd_r <= 8'd0;
            cnt   <= 3'd0;
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= step_q;
          {bcd_r, bin_r} <= step_r;
          cnt            <= cnt + 3'd1;
          // Digits load from the result of the sixth step, not the stale accumulator.
          if (cnt == 3'd5) begin
            if (dz) begin
              {quo_tens, quo_ones} <= 8'hFF;
              {rem_tens, rem_ones} <= 8'hFF;
              err                  <= 1'b1;
            end else begin
              {quo_tens, quo_ones} <= step_q[13:6];
              {rem_tens, rem_ones} <= step_r[13:6];
              err                  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// tb/tb_div_result_bcd.sv - randomized self-checking bench for div_result_bcd
// Reference model uses plain decimal arithmetic (v/10, v%10).
module tb_div_result_bcd;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] quo;
  logic [5:0] rem;
  logic [2:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] quo_tens, quo_ones, rem_tens, rem_ones;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

  div_result_bcd dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .quo(quo), .rem(rem), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quo_tens(quo_tens), .quo_ones(quo_ones),
    .rem_tens(rem_tens), .rem_ones(rem_ones), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input int q, input int r, input int d);
    logic [3:0] qt, qo, rt, ro;
    if (d == 0) return {16'hFFFF, 1'b1};
    qt = 4'(q / 10); qo = 4'(q % 10); rt = 4'(r / 10); ro = 4'(r % 10);
    return {qt, qo, rt, ro, 1'b0};
  endfunction

  function automatic logic [16:0] observed();
    return {quo_tens, quo_ones, rem_tens, rem_ones, err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, accepts one operand set, counts edges until out_valid.
  task automatic run_one(input logic [5:0] q, input logic [5:0] r, input logic [2:0] d,
                         output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    quo = q; rem = r; divisor = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; quo = '0; rem = '0; divisor = '0;
    tick(); tick();
    rst_n = 1'b1;
    vectors++;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, 17'd0}) begin
      miscompares++;
      $display("FAIL reset: got ov=%b ir=%b res=%h, need ov=0 ir=1 res=0",
               out_valid, in_ready, observed());
    end
  endtask

  task automatic test_directed();
    int lat;
    int tq[4] = '{7, 63, 0, 12};
    int tr[4] = '{3, 0, 5, 59};
    int td[4] = '{6, 1, 7, 3};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_one(6'(tq[i]), 6'(tr[i]), 3'(td[i]), lat);
      vectors++;
      if (lat != 6) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d edges, need 6", i, lat);
      end
      vectors++;
      if (observed() !== model(tq[i], tr[i], td[i])) begin
        miscompares++;
        $display("FAIL directed_digits[%0d]: got %h, need %h", i, observed(), model(tq[i], tr[i], td[i]));
      end
      tick();
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
        miscompares++;
        $display("FAIL directed_return_idle[%0d]: got ir=%b ov=%b, need ir=1 ov=0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    out_ready = 1'b1;
    run_one(6'd63, 6'd63, 3'd0, lat);
    vectors++;
    if (lat != 6 || observed() !== model(63, 63, 0)) begin
      miscompares++;
      $display("FAIL div_zero: got lat=%0d res=%h, need lat=6 res=%h", lat, observed(), model(63, 63, 0));
    end
    tick();
  endtask

  task automatic test_random();
    int lat, q, r, d;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      q = $urandom_range(63); r = $urandom_range(63); d = $urandom_range(7);
      run_one(6'(q), 6'(r), 3'(d), lat);
      vectors++;
      if (lat != 6 || observed() !== model(q, r, d)) begin
        miscompares++;
        $display("FAIL random[%0d] q=%0d r=%0d d=%0d: got lat=%0d res=%h, need lat=6 res=%h",
                 i, q, r, d, lat, observed(), model(q, r, d));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat, q, r;
    logic [16:0] held;
    q = $urandom_range(63); r = $urandom_range(63);
    out_ready = 1'b0;
    run_one(6'(q), 6'(r), 3'd5, lat);
    held = model(q, r, 5);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; quo = 6'($urandom_range(63)); rem = 6'($urandom_range(63)); divisor = 3'd0;
      tick();
      vectors++;
      if ({out_valid, in_ready, observed()} !== {1'b1, 1'b0, held}) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: got ov=%b ir=%b res=%h, need ov=1 ir=0 res=%h",
                 i, out_valid, in_ready, observed(), held);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    vectors++;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, held}) begin
      miscompares++;
      $display("FAIL backpressure_release: got ov=%b ir=%b res=%h, need ov=0 ir=1 res=%h",
               out_valid, in_ready, observed(), held);
    end
    tick();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL backpressure_idle: got ov=%b ir=%b, need ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_conv();
    int lat;
    out_ready = 1'b1;
    quo = 6'd45; rem = 6'd2; divisor = 3'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, 17'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_conv: got ov=%b ir=%b res=%h, need ov=0 ir=1 res=0",
               out_valid, in_ready, observed());
    end
    run_one(6'd12, 6'd4, 3'd5, lat);
    vectors++;
    if (lat != 6 || observed() !== model(12, 4, 5)) begin
      miscompares++;
      $display("FAIL reset_resend: got lat=%0d res=%h, need lat=6 res=%h", lat, observed(), model(12, 4, 5));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_q[$];
    int sent, got, last_cyc, cyc;
    logic acc;
    sent = 0; got = 0; last_cyc = -1;
    out_ready = 1'b1;
    quo = 6'($urandom_range(63)); rem = 6'($urandom_range(63)); divisor = 3'($urandom_range(7));
    in_valid = 1'b1;
    for (cyc = 0; cyc < 60 && got < 4; cyc++) begin
      acc = in_ready && in_valid;
      if (acc) exp_q.push_back(model(quo, rem, divisor));
      tick();
      if (acc) begin
        sent++;
        if (sent < 4) begin
          quo = 6'($urandom_range(63)); rem = 6'($urandom_range(63)); divisor = 3'($urandom_range(7));
        end else in_valid = 1'b0;
      end
      if (out_valid) begin
        vectors++;
        if (exp_q.size() == 0 || observed() !== exp_q[0]) begin
          miscompares++;
          $display("FAIL b2b_result[%0d]: got %h, need %h", got, observed(),
                   exp_q.size() ? exp_q[0] : 17'h0);
        end
        if (exp_q.size()) void'(exp_q.pop_front());
        if (last_cyc >= 0) begin
          vectors++;
          if (cyc - last_cyc != 8) begin
            miscompares++;
            $display("FAIL b2b_interval[%0d]: got %0d cycles, need 8", got, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (got != 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results, need 4", got);
    end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_random();
    test_backpressure();
    test_reset_mid_conv();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
